fifo_sync_flags: RTL and testbench
==================================

Name: fifo_sync_flags

Overview:
Parametrised successor to the team's single-clock array FIFO, generalised in the following ways:
- Arbitrary (non-power-of-two) depth.
- Occupancy count output.
- Programmable almost-full and almost-empty thresholds.
- Sticky overflow/underflow error flags.
- Selectable output mode: registered read or first-word-fall-through (FWFT).

It sits between producer and consumer blocks in the same clock domain, as a drop-in buffer with richer status.

Parameters:
- SIZE_DATA, 8, data word width in bits (>=1).
- SIZE_DEPTH, 8, number of entries (>=2, any integer).
- AFULL_THR, SIZE_DEPTH-2, o_almost_full asserted when count >= AFULL_THR (1..SIZE_DEPTH).
- AEMPTY_THR, 1, o_almost_empty asserted when count <= AEMPTY_THR (0..SIZE_DEPTH-1).
- FWFT, 0, 0 = registered read; 1 = first-word-fall-through.

Ports:
- i_clk, input, 1, clock; all state updates on rising edge.
- i_rst_n, input, 1, reset; asynchronous, active-low.
- i_wr_en, input, 1, write request.
- i_data, input, SIZE_DATA, write data.
- i_rd_en, input, 1, read request (FWFT=1: pop/acknowledge of current o_data).
- i_clr_err, input, 1, synchronous clear of sticky error flags.
- o_data, output, SIZE_DATA, read data.
- o_valid, output, 1, o_data holds a word delivered by an accepted read (FWFT=0) or a head word (FWFT=1).
- o_full, output, 1, count == SIZE_DEPTH.
- o_empty, output, 1, count == 0.
- o_almost_full, output, 1, threshold flag.
- o_almost_empty, output, 1, threshold flag.
- o_count, output, $clog2(SIZE_DEPTH+1), current occupancy.
- o_overflow, output, 1, sticky: a write was dropped.
- o_underflow, output, 1, sticky: a read was rejected.

Behaviour:

Reset (asynchronous, i_rst_n=0):
- Pointers = 0, o_count = 0, o_data = 0, o_valid = 0.
- o_empty = 1, o_full = 0, o_almost_empty = 1, o_almost_full = 0.
- o_overflow = 0, o_underflow = 0.
- Reset mid-operation discards all contents immediately; RAM contents need not be cleared.

Accept rules (evaluated on flags before the edge):
- wr_ok = i_wr_en & (!o_full | rd_ok).
- rd_ok = i_rd_en & !o_empty.
- Full with both requests: read and write both accepted, count unchanged.
- Empty with both requests: write accepted, read rejected.

Count update:
- o_count += wr_ok - rd_ok.
- All flags are registered and derived from the next count, so they are valid the cycle after the edge with no combinational path from inputs.

Pointer wrap:
- Each pointer increments on accept and wraps from SIZE_DEPTH-1 to 0, with an explicit compare (no reliance on power-of-two depth).

Errors:
- i_wr_en & !wr_ok sets o_overflow; the data is dropped and the pointer is not moved.
- i_rd_en & !rd_ok sets o_underflow.
- Flags hold until i_clr_err=1 at an edge. If clear and a new error occur in the same cycle, the error wins (flag stays 1).

FWFT=0 (registered read):
- On rd_ok, o_data <= mem[rd_ptr] and o_valid <= 1 at the same edge; data is visible one cycle after the request edge.
- If there is no rd_ok, o_valid <= 0 and o_data holds its last value.

FWFT=1 (first-word-fall-through):
- o_data continuously presents mem[rd_ptr]; o_valid = !o_empty.
- A write into an empty FIFO shows on o_data the cycle after the write edge.
- rd_ok advances to the next word at the edge.

Writes:
- mem[wr_ptr] <= i_data on wr_ok.
- A same-cycle read of the same slot (full with both requests) returns the old word.

Decomposition:
- Package fifo_pkg holds:
  - Function clog2-based width helpers (count width = $clog2(SIZE_DEPTH+1)).
  - Localparam defaults for SIZE_DATA and SIZE_DEPTH.
  - An enum for output mode: FIFO_MODE_REG = 0, FIFO_MODE_FWFT = 1.
- One sub-module, fifo_mem_dp: simple dual-port register array with a synchronous write port and an asynchronous read port (SIZE_DATA x SIZE_DEPTH).
- Control, pointers, count and flags stay in the top module.

Test Plan:
1. Reset then idle, SIZE_DEPTH=8, FWFT=0 -> o_empty=1, o_almost_empty=1, o_count=0, o_data=00, all other flags 0.
2. Write 8 words 0x29..0x30 (9 write requests in total) -> o_almost_full=1 once count=6, o_full=1 at count=8, 9th write dropped, o_overflow=1, o_count stays 8.
3. Read 9 times, FWFT=0 -> o_data = 0x29..0x30 in order, each one cycle after its request with o_valid=1; o_empty=1 after the 8th read; 9th read sets o_underflow=1. Then i_clr_err=1 for one cycle -> both sticky flags 0.
4. Full FIFO with i_wr_en=i_rd_en=1 for 4 cycles, data 0x40..0x43 -> o_count stays 8, o_full stays 1, no overflow, oldest 4 words popped in order.
5. FWFT=1, SIZE_DEPTH=5 (non-power-of-two): write 0x11 into empty -> next cycle o_data=0x11, o_valid=1. Fill and drain through two full pointer wraps -> data order is preserved and the wrap from pointer 4 to 0 is correct.
6. Assert i_rst_n=0 asynchronously mid-burst with count=3 -> flags and count return to reset values without waiting for a clock edge; the first read after release returns the first new write.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types, defaults and width helpers for the flagged sync FIFO.
// Imported by the interface, the storage array and the top.
package fifo_pkg;

    localparam int FIFO_SIZE_DATA  = 8;
    localparam int FIFO_SIZE_DEPTH = 8;

    typedef enum logic {
        FIFO_MODE_REG  = 1'b0,
        FIFO_MODE_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int fifo_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int fifo_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer bundle of the flagged sync FIFO.
// master drives requests, slave is the FIFO itself.
interface fifo_sync_flags_if
    import fifo_pkg::*;
#(
    parameter int SIZE_DATA  = FIFO_SIZE_DATA,
    parameter int SIZE_DEPTH = FIFO_SIZE_DEPTH
);

    localparam int CW = fifo_cnt_width(SIZE_DEPTH);

    logic                 i_wr_en;
    logic [SIZE_DATA-1:0] i_data;
    logic                 i_rd_en;
    logic                 i_clr_err;
    logic [SIZE_DATA-1:0] o_data;
    logic                 o_valid;
    logic                 o_full;
    logic                 o_empty;
    logic                 o_almost_full;
    logic                 o_almost_empty;
    logic [CW-1:0]        o_count;
    logic                 o_overflow;
    logic                 o_underflow;

    modport master (
        output i_wr_en, i_data, i_rd_en, i_clr_err,
        input  o_data, o_valid, o_full, o_empty,
        input  o_almost_full, o_almost_empty, o_count,
        input  o_overflow, o_underflow
    );

    modport slave (
        input  i_wr_en, i_data, i_rd_en, i_clr_err,
        output o_data, o_valid, o_full, o_empty,
        output o_almost_full, o_almost_empty, o_count,
        output o_overflow, o_underflow
    );

endinterface

// File: rtl/fifo_mem_dp.sv
// Dual-port register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter int SIZE_DATA  = FIFO_SIZE_DATA,
    parameter int SIZE_DEPTH = FIFO_SIZE_DEPTH,
    parameter int PW         = fifo_ptr_width(SIZE_DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_wr_en,
    input  logic [PW-1:0]        i_wr_addr,
    input  logic [SIZE_DATA-1:0] i_wr_data,
    input  logic [PW-1:0]        i_rd_addr,
    output logic [SIZE_DATA-1:0] o_rd_data
);

    logic [SIZE_DATA-1:0] mem [SIZE_DEPTH];

    // Store the incoming word at the write address
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with any depth, occupancy, thresholds,
// sticky error flags and registered or fall-through output.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int SIZE_DATA  = FIFO_SIZE_DATA,
    parameter int SIZE_DEPTH = FIFO_SIZE_DEPTH,
    parameter int AFULL_THR  = SIZE_DEPTH - 2,
    parameter int AEMPTY_THR = 1,
    parameter int FWFT       = 0
) (
    input logic              i_clk,
    input logic              i_rst_n,
    fifo_sync_flags_if.slave bus
);

    localparam int CW = fifo_cnt_width(SIZE_DEPTH);
    localparam int PW = fifo_ptr_width(SIZE_DEPTH);

    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [PW-1:0]        wr_ptr_nxt;
    logic [PW-1:0]        rd_ptr_nxt;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_nxt;
    logic                 full_q;
    logic                 empty_q;
    logic                 afull_q;
    logic                 aempty_q;
    logic                 ovf_q;
    logic                 udf_q;
    logic                 ovf_nxt;
    logic                 udf_nxt;
    logic                 wr_ok;
    logic                 rd_ok;
    logic [SIZE_DATA-1:0] rd_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SIZE_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A read frees a slot, so a full FIFO still takes a paired write
    assign rd_ok = bus.i_rd_en & ~empty_q;
    assign wr_ok = bus.i_wr_en & (~full_q | rd_ok);

    // Next occupancy, pointers and sticky error state
    always_comb begin
        count_nxt  = count_q;
        wr_ptr_nxt = wr_ptr_q;
        rd_ptr_nxt = rd_ptr_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
        if (wr_ok) begin
            wr_ptr_nxt = ptr_inc(wr_ptr_q);
        end
        if (rd_ok) begin
            rd_ptr_nxt = ptr_inc(rd_ptr_q);
        end
        ovf_nxt = (bus.i_wr_en & ~wr_ok) | (ovf_q & ~bus.i_clr_err);
        udf_nxt = (bus.i_rd_en & ~rd_ok) | (udf_q & ~bus.i_clr_err);
    end

    // Pointers, count and all status flags, registered off the next count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_nxt;
            rd_ptr_q <= rd_ptr_nxt;
            count_q  <= count_nxt;
            full_q   <= (count_nxt == CW'(SIZE_DEPTH));
            empty_q  <= (count_nxt == '0);
            afull_q  <= (count_nxt >= CW'(AFULL_THR));
            aempty_q <= (count_nxt <= CW'(AEMPTY_THR));
            ovf_q    <= ovf_nxt;
            udf_q    <= udf_nxt;
        end
    end

    fifo_mem_dp #(
        .SIZE_DATA  (SIZE_DATA),
        .SIZE_DEPTH (SIZE_DEPTH),
        .PW         (PW)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (wr_ok),
        .i_wr_addr (wr_ptr_q),
        .i_wr_data (bus.i_data),
        .i_rd_addr (rd_ptr_q),
        .o_rd_data (rd_data)
    );

    generate
        if (FWFT == int'(FIFO_MODE_FWFT)) begin : g_fwft
            assign bus.o_data  = rd_data;
            assign bus.o_valid = ~empty_q;
        end else begin : g_reg
            logic [SIZE_DATA-1:0] data_q;
            logic                 valid_q;

            // Capture the head word on an accepted read, else hold it
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_ok;
                    if (rd_ok) begin
                        data_q <= rd_data;
                    end
                end
            end

            assign bus.o_data  = data_q;
            assign bus.o_valid = valid_q;
        end
    endgenerate

    assign bus.o_count        = count_q;
    assign bus.o_full         = full_q;
    assign bus.o_empty        = empty_q;
    assign bus.o_almost_full  = afull_q;
    assign bus.o_almost_empty = aempty_q;
    assign bus.o_overflow     = ovf_q;
    assign bus.o_underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags: registered depth-8 instance driven
// from a vector table, fall-through depth-5 instance by sequences.
module tb_fifo_sync_flags;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fifo_sync_flags_if #(.SIZE_DATA(8), .SIZE_DEPTH(8)) bus_a ();
    fifo_sync_flags_if #(.SIZE_DATA(8), .SIZE_DEPTH(5)) bus_b ();

    fifo_sync_flags #(
        .SIZE_DATA(8), .SIZE_DEPTH(8), .AFULL_THR(6),
        .AEMPTY_THR(1), .FWFT(0)
    ) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_a)
    );

    fifo_sync_flags #(
        .SIZE_DATA(8), .SIZE_DEPTH(5), .AFULL_THR(3),
        .AEMPTY_THR(1), .FWFT(1)
    ) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_b)
    );

    // flags = {full, empty, afull, aempty, ovf, udf, valid}
    typedef struct {
        logic       wr;
        logic       rd;
        logic       clr;
        logic [7:0] din;
        int         cnt;
        logic [6:0] flags;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic wr, input logic rd, input logic clr,
                       input logic [7:0] din, input int cnt,
                       input logic [6:0] flags, input logic [7:0] data);
        vec_t v;
        v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
        v.cnt = cnt; v.flags = flags; v.data = data;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step_a(input logic wr, input logic rd,
                          input logic clr, input logic [7:0] din);
        @(negedge clk);
        bus_a.i_wr_en = wr; bus_a.i_rd_en = rd;
        bus_a.i_clr_err = clr; bus_a.i_data = din;
        @(posedge clk);
        #1;
        bus_a.i_wr_en = 1'b0; bus_a.i_rd_en = 1'b0;
        bus_a.i_clr_err = 1'b0;
    endtask

    task automatic step_b(input logic wr, input logic rd,
                          input logic clr, input logic [7:0] din);
        @(negedge clk);
        bus_b.i_wr_en = wr; bus_b.i_rd_en = rd;
        bus_b.i_clr_err = clr; bus_b.i_data = din;
        @(posedge clk);
        #1;
        bus_b.i_wr_en = 1'b0; bus_b.i_rd_en = 1'b0;
        bus_b.i_clr_err = 1'b0;
    endtask

    task automatic chk_a(input string tag, input int cnt,
                         input logic [6:0] f, input logic [7:0] d);
        chk({tag, " count"},  32'(bus_a.o_count), cnt);
        chk({tag, " full"},   32'(bus_a.o_full), 32'(f[6]));
        chk({tag, " empty"},  32'(bus_a.o_empty), 32'(f[5]));
        chk({tag, " afull"},  32'(bus_a.o_almost_full), 32'(f[4]));
        chk({tag, " aempty"}, 32'(bus_a.o_almost_empty), 32'(f[3]));
        chk({tag, " ovf"},    32'(bus_a.o_overflow), 32'(f[2]));
        chk({tag, " udf"},    32'(bus_a.o_underflow), 32'(f[1]));
        chk({tag, " valid"},  32'(bus_a.o_valid), 32'(f[0]));
        chk({tag, " data"},   32'(bus_a.o_data), 32'(d));
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] e;

    initial begin
        bus_a.i_wr_en = 0; bus_a.i_rd_en = 0;
        bus_a.i_clr_err = 0; bus_a.i_data = 0;
        bus_b.i_wr_en = 0; bus_b.i_rd_en = 0;
        bus_b.i_clr_err = 0; bus_b.i_data = 0;

        // writes 0x29..0x30 plus one dropped
        add(1,0,0,8'h29,1,7'b0001000,8'h00);
        add(1,0,0,8'h2a,2,7'b0000000,8'h00);
        add(1,0,0,8'h2b,3,7'b0000000,8'h00);
        add(1,0,0,8'h2c,4,7'b0000000,8'h00);
        add(1,0,0,8'h2d,5,7'b0000000,8'h00);
        add(1,0,0,8'h2e,6,7'b0010000,8'h00);
        add(1,0,0,8'h2f,7,7'b0010000,8'h00);
        add(1,0,0,8'h30,8,7'b1010000,8'h00);
        add(1,0,0,8'h31,8,7'b1010100,8'h00);
        // nine reads, last one rejected, then clear
        add(0,1,0,8'h00,7,7'b0010101,8'h29);
        add(0,1,0,8'h00,6,7'b0010101,8'h2a);
        add(0,1,0,8'h00,5,7'b0000101,8'h2b);
        add(0,1,0,8'h00,4,7'b0000101,8'h2c);
        add(0,1,0,8'h00,3,7'b0000101,8'h2d);
        add(0,1,0,8'h00,2,7'b0000101,8'h2e);
        add(0,1,0,8'h00,1,7'b0001101,8'h2f);
        add(0,1,0,8'h00,0,7'b0101101,8'h30);
        add(0,1,0,8'h00,0,7'b0101110,8'h30);
        add(0,0,1,8'h00,0,7'b0101000,8'h30);
        // refill with 0x20..0x27
        add(1,0,0,8'h20,1,7'b0001000,8'h30);
        add(1,0,0,8'h21,2,7'b0000000,8'h30);
        add(1,0,0,8'h22,3,7'b0000000,8'h30);
        add(1,0,0,8'h23,4,7'b0000000,8'h30);
        add(1,0,0,8'h24,5,7'b0000000,8'h30);
        add(1,0,0,8'h25,6,7'b0010000,8'h30);
        add(1,0,0,8'h26,7,7'b0010000,8'h30);
        add(1,0,0,8'h27,8,7'b1010000,8'h30);
        // full with paired read/write
        add(1,1,0,8'h40,8,7'b1010001,8'h20);
        add(1,1,0,8'h41,8,7'b1010001,8'h21);
        add(1,1,0,8'h42,8,7'b1010001,8'h22);
        add(1,1,0,8'h43,8,7'b1010001,8'h23);
        // drain
        add(0,1,0,8'h00,7,7'b0010001,8'h24);
        add(0,1,0,8'h00,6,7'b0010001,8'h25);
        add(0,1,0,8'h00,5,7'b0000001,8'h26);
        add(0,1,0,8'h00,4,7'b0000001,8'h27);
        add(0,1,0,8'h00,3,7'b0000001,8'h40);
        add(0,1,0,8'h00,2,7'b0000001,8'h41);
        add(0,1,0,8'h00,1,7'b0001001,8'h42);
        add(0,1,0,8'h00,0,7'b0101001,8'h43);
        // empty with both: write taken, read rejected
        add(1,1,0,8'h55,1,7'b0001010,8'h43);
        add(0,1,1,8'h00,0,7'b0101001,8'h55);
        // clear and new error together: error wins
        add(0,1,1,8'h00,0,7'b0101010,8'h55);
        add(0,0,1,8'h00,0,7'b0101000,8'h55);

        #12;
        chk_a("reset", 0, 7'b0101000, 8'h00);
        chk("reset b empty", 32'(bus_b.o_empty), 1);
        chk("reset b valid", 32'(bus_b.o_valid), 0);
        chk("reset b count", 32'(bus_b.o_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_a("idle", 0, 7'b0101000, 8'h00);

        foreach (vecs[i]) begin
            step_a(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
            chk_a($sformatf("vec%0d", i), vecs[i].cnt,
                  vecs[i].flags, vecs[i].data);
        end

        // fall-through: first word shows the cycle after its write
        step_b(1, 0, 0, 8'h11);
        chk("fwft first valid", 32'(bus_b.o_valid), 1);
        chk("fwft first data", 32'(bus_b.o_data), 32'h11);
        chk("fwft first count", 32'(bus_b.o_count), 1);
        exp_q.push_back(8'h11);
        for (int i = 2; i <= 5; i++) begin
            step_b(1, 0, 0, 8'(8'h10 + i));
            exp_q.push_back(8'(8'h10 + i));
            chk($sformatf("fwft fill%0d count", i),
                32'(bus_b.o_count), i);
            chk($sformatf("fwft fill%0d afull", i),
                32'(bus_b.o_almost_full), (i >= 3) ? 1 : 0);
        end
        chk("fwft full", 32'(bus_b.o_full), 1);
        step_b(1, 0, 0, 8'h99);
        chk("fwft ovf", 32'(bus_b.o_overflow), 1);
        chk("fwft ovf count", 32'(bus_b.o_count), 5);
        step_b(0, 0, 1, 8'h00);
        chk("fwft ovf clr", 32'(bus_b.o_overflow), 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("fwft head valid", 32'(bus_b.o_valid), 1);
            chk("fwft head data", 32'(bus_b.o_data), 32'(e));
            step_b(0, 1, 0, 8'h00);
        end
        chk("fwft drained empty", 32'(bus_b.o_empty), 1);
        chk("fwft drained valid", 32'(bus_b.o_valid), 0);

        // shift pointers off zero, then two rounds wrapping 4->0
        for (int i = 0; i < 2; i++) begin
            step_b(1, 0, 0, 8'(8'h70 + i));
        end
        for (int i = 0; i < 2; i++) begin
            chk("fwft skew data", 32'(bus_b.o_data), 32'(8'h70 + i));
            step_b(0, 1, 0, 8'h00);
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) begin
                step_b(1, 0, 0, 8'(8'h80 + 16 * r + i));
                exp_q.push_back(8'(8'h80 + 16 * r + i));
            end
            chk($sformatf("wrap%0d full", r), 32'(bus_b.o_full), 1);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("wrap%0d data", r),
                    32'(bus_b.o_data), 32'(e));
                step_b(0, 1, 0, 8'h00);
            end
            chk($sformatf("wrap%0d empty", r), 32'(bus_b.o_empty), 1);
        end

        // asynchronous reset mid-burst with three words held
        step_a(1, 0, 0, 8'h61);
        step_a(1, 0, 0, 8'h62);
        step_a(1, 0, 0, 8'h63);
        chk("pre-rst count", 32'(bus_a.o_count), 3);
        @(negedge clk);
        bus_a.i_wr_en = 1'b1;
        bus_a.i_data = 8'h64;
        #2;
        rst_n = 1'b0;
        #1;
        chk_a("async rst", 0, 7'b0101000, 8'h00);
        bus_a.i_wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step_a(1, 0, 0, 8'h71);
        chk("post-rst count", 32'(bus_a.o_count), 1);
        step_a(0, 1, 0, 8'h00);
        chk("post-rst valid", 32'(bus_a.o_valid), 1);
        chk("post-rst data", 32'(bus_a.o_data), 32'h71);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
